psram_rd_checker: RTL and testbench

//   Read-data checker on the user side of psram_controller, beside psram_rw, in the ram_clk domain.

---
 rtl/psram_rd_checker.sv | 173 +++++++++++++++++
 tb/tb_psram_rd_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_rd_checker.sv
// Read-data checker for psram_rw bursts: compares each beat against the incrementing
// address pattern and keeps burst, error and timeout statistics in the ram_clk domain.
module psram_rd_checker #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned BURST_LEN = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                   ram_clk,
  input  logic                   ram_rst,
  input  logic                   init_cable_complete,
  input  logic                   rd_start,
  input  logic [31:0]            rd_addr,
  input  logic                   ram_rd_valid,
  input  logic [2*BIT_WIDTH-1:0] ram_data_out,
  output logic                   chk_busy,
  output logic                   burst_done,
  output logic [31:0]            burst_cnt,
  output logic [15:0]            err_cnt,
  output logic                   err_flag,
  output logic [31:0]            first_err_addr,
  output logic                   timeout_flag
);

  localparam int unsigned DW    = 2 * BIT_WIDTH;
  localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT - 1);
  localparam logic [15:0]      ERR_SAT  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        base, base_nxt;
  logic [IDX_W-1:0]   beat_idx, beat_idx_nxt;
  logic [TMO_W-1:0]   tmo, tmo_nxt;
  logic               first_seen, first_seen_nxt;

  logic               chk_busy_nxt;
  logic               burst_done_nxt;
  logic [31:0]        burst_cnt_nxt;
  logic [15:0]        err_cnt_nxt;
  logic               err_flag_nxt;
  logic [31:0]        first_err_addr_nxt;
  logic               timeout_flag_nxt;

  logic [31:0]        beat_addr;
  logic [DW-1:0]      exp_word;

  assign beat_addr = base + 32'(beat_idx);
  assign exp_word  = DW'(beat_addr);

  // Next-state and next-output logic
  always_comb begin
    state_nxt          = state;
    base_nxt           = base;
    beat_idx_nxt       = beat_idx;
    tmo_nxt            = tmo;
    first_seen_nxt     = first_seen;
    burst_done_nxt     = 1'b0;
    burst_cnt_nxt      = burst_cnt;
    err_cnt_nxt        = err_cnt;
    err_flag_nxt       = err_flag;
    first_err_addr_nxt = first_err_addr;
    timeout_flag_nxt   = timeout_flag;

    if (!init_cable_complete) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_ARMED;
        end

        S_ARMED: begin
          if (ram_rd_valid) begin
            err_flag_nxt = 1'b1;
          end
          if (rd_start) begin
            base_nxt     = rd_addr;
            beat_idx_nxt = '0;
            tmo_nxt      = '0;
            state_nxt    = S_CHECK;
          end
        end

        S_CHECK: begin
          if (ram_rd_valid) begin
            tmo_nxt      = '0;
            beat_idx_nxt = beat_idx + IDX_W'(1);
            if (ram_data_out != exp_word) begin
              err_flag_nxt = 1'b1;
              if (err_cnt != ERR_SAT) begin
                err_cnt_nxt = err_cnt + 16'd1;
              end
              if (!first_seen) begin
                first_seen_nxt     = 1'b1;
                first_err_addr_nxt = beat_addr;
              end
            end
            if (beat_idx == LAST_IDX) begin
              burst_done_nxt = 1'b1;
              burst_cnt_nxt  = burst_cnt + 32'd1;
              // A start coinciding with the last beat chains straight into the next burst
              if (rd_start) begin
                base_nxt     = rd_addr;
                beat_idx_nxt = '0;
              end else begin
                state_nxt = S_ARMED;
              end
            end else if (rd_start) begin
              err_flag_nxt = 1'b1;
            end
          end else begin
            if (rd_start) begin
              err_flag_nxt = 1'b1;
            end
            if (tmo == TMO_MAX) begin
              timeout_flag_nxt = 1'b1;
              burst_done_nxt   = 1'b1;
              state_nxt        = S_ARMED;
            end else begin
              tmo_nxt = tmo + TMO_W'(1);
            end
          end
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    chk_busy_nxt = (state_nxt == S_CHECK);
  end

  // State and output registers
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      state          <= S_IDLE;
      base           <= '0;
      beat_idx       <= '0;
      tmo            <= '0;
      first_seen     <= 1'b0;
      chk_busy       <= 1'b0;
      burst_done     <= 1'b0;
      burst_cnt      <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
      timeout_flag   <= 1'b0;
    end else begin
      state          <= state_nxt;
      base           <= base_nxt;
      beat_idx       <= beat_idx_nxt;
      tmo            <= tmo_nxt;
      first_seen     <= first_seen_nxt;
      chk_busy       <= chk_busy_nxt;
      burst_done     <= burst_done_nxt;
      burst_cnt      <= burst_cnt_nxt;
      err_cnt        <= err_cnt_nxt;
      err_flag       <= err_flag_nxt;
      first_err_addr <= first_err_addr_nxt;
      timeout_flag   <= timeout_flag_nxt;
    end
  end

endmodule

// File: tb/tb_psram_rd_checker.sv
// Directed bench for psram_rd_checker: bursts, mismatches, timeout, chaining,
// stray beats, error saturation, reset and init drop.
module tb_psram_rd_checker;

  localparam int unsigned BIT_WIDTH = 16;
  localparam int unsigned BURST_LEN = 32;
  localparam int unsigned TIMEOUT   = 16;

  logic        ram_clk = 1'b0;
  logic        ram_rst;
  logic        init_cable_complete;
  logic        rd_start;
  logic [31:0] rd_addr;
  logic        ram_rd_valid;
  logic [31:0] ram_data_out;
  logic        chk_busy;
  logic        burst_done;
  logic [31:0] burst_cnt;
  logic [15:0] err_cnt;
  logic        err_flag;
  logic [31:0] first_err_addr;
  logic        timeout_flag;

  int n_tests = 0;
  int n_fail  = 0;

  psram_rd_checker #(
    .BIT_WIDTH (BIT_WIDTH),
    .BURST_LEN (BURST_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .ram_clk             (ram_clk),
    .ram_rst             (ram_rst),
    .init_cable_complete (init_cable_complete),
    .rd_start            (rd_start),
    .rd_addr             (rd_addr),
    .ram_rd_valid        (ram_rd_valid),
    .ram_data_out        (ram_data_out),
    .chk_busy            (chk_busy),
    .burst_done          (burst_done),
    .burst_cnt           (burst_cnt),
    .err_cnt             (err_cnt),
    .err_flag            (err_flag),
    .first_err_addr      (first_err_addr),
    .timeout_flag        (timeout_flag)
  );

  always #5 ram_clk = ~ram_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ram_clk);
    #1;
  endtask

  // Drive beats first..first+n-1 of a burst at base; bad_idx beat carries 0xDEAD
  task automatic run_beats(input logic [31:0] base, input int first, input int n,
                           input int bad_idx, output int dones);
    dones = 0;
    for (int k = first; k < first + n; k++) begin
      ram_rd_valid = 1'b1;
      ram_data_out = (k == bad_idx) ? 32'h0000_DEAD : base + 32'(k);
      tick();
      if (burst_done) dones++;
    end
    ram_rd_valid = 1'b0;
    ram_data_out = '0;
  endtask

  task automatic start_burst(input logic [31:0] addr);
    rd_start = 1'b1;
    rd_addr  = addr;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(chk_busy),     32'd0);
    check({tag, "_done"},  32'(burst_done),   32'd0);
    check({tag, "_bcnt"},  burst_cnt,         32'd0);
    check({tag, "_ecnt"},  32'(err_cnt),      32'd0);
    check({tag, "_eflg"},  32'(err_flag),     32'd0);
    check({tag, "_fadr"},  first_err_addr,    32'd0);
    check({tag, "_tmo"},   32'(timeout_flag), 32'd0);
  endtask

  initial begin
    int dones;
    int extra;

    ram_rst = 1'b1;
    init_cable_complete = 1'b0;
    rd_start = 1'b0;
    rd_addr = '0;
    ram_rd_valid = 1'b0;
    ram_data_out = '0;
    tick();
    tick();
    check_all_zero("rst");

    // 1: clean burst
    ram_rst = 1'b0;
    init_cable_complete = 1'b1;
    tick();
    tick();
    start_burst(32'h100);
    check("t1_busy", 32'(chk_busy), 32'd1);
    run_beats(32'h100, 0, 32, -1, dones);
    check("t1_dones", 32'(dones), 32'd1);
    check("t1_bcnt", burst_cnt, 32'd1);
    check("t1_ecnt", 32'(err_cnt), 32'd0);
    check("t1_eflg", 32'(err_flag), 32'd0);
    check("t1_idle_busy", 32'(chk_busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(burst_done), 32'd0);

    // 2: mismatch at beat 5, then a second bad burst
    start_burst(32'h100);
    run_beats(32'h100, 0, 5, -1, dones);
    run_beats(32'h100, 5, 1, 5, dones);
    check("t2_lat_ecnt", 32'(err_cnt), 32'd1);
    check("t2_lat_eflg", 32'(err_flag), 32'd1);
    run_beats(32'h100, 6, 26, -1, dones);
    check("t2_ecnt", 32'(err_cnt), 32'd1);
    check("t2_fadr", first_err_addr, 32'h105);
    check("t2_bcnt", burst_cnt, 32'd2);
    start_burst(32'h200);
    run_beats(32'h200, 0, 32, 7, dones);
    check("t2b_ecnt", 32'(err_cnt), 32'd2);
    check("t2b_fadr", first_err_addr, 32'h105);
    check("t2b_bcnt", burst_cnt, 32'd3);

    // 3: stall after 3 beats
    start_burst(32'h300);
    run_beats(32'h300, 0, 3, -1, dones);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (burst_done || timeout_flag) extra++;
    end
    check("t3_early", 32'(extra), 32'd0);
    tick();
    check("t3_tmo", 32'(timeout_flag), 32'd1);
    check("t3_done", 32'(burst_done), 32'd1);
    check("t3_busy", 32'(chk_busy), 32'd0);
    check("t3_bcnt", burst_cnt, 32'd3);
    tick();
    check("t3_done_pulse", 32'(burst_done), 32'd0);

    // 4: rd_start on the last beat chains a new burst
    start_burst(32'h400);
    run_beats(32'h400, 0, 31, -1, dones);
    rd_start = 1'b1;
    rd_addr = 32'h1000;
    ram_rd_valid = 1'b1;
    ram_data_out = 32'h41F;
    tick();
    rd_start = 1'b0;
    ram_rd_valid = 1'b0;
    check("t4_done", 32'(burst_done), 32'd1);
    check("t4_bcnt", burst_cnt, 32'd4);
    check("t4_busy", 32'(chk_busy), 32'd1);
    run_beats(32'h1000, 0, 32, -1, dones);
    check("t4_dones2", 32'(dones), 32'd1);
    check("t4_bcnt2", burst_cnt, 32'd5);
    check("t4_ecnt", 32'(err_cnt), 32'd2);

    // 5: stray beat in ARMED, then saturation
    ram_rst = 1'b1;
    tick();
    ram_rst = 1'b0;
    tick();
    tick();
    ram_rd_valid = 1'b1;
    ram_data_out = 32'h1234;
    tick();
    ram_rd_valid = 1'b0;
    tick();
    check("t5_stray_eflg", 32'(err_flag), 32'd1);
    check("t5_stray_ecnt", 32'(err_cnt), 32'd0);
    check("t5_stray_busy", 32'(chk_busy), 32'd0);
    rd_start = 1'b1;
    rd_addr = 32'h50;
    ram_rd_valid = 1'b1;
    ram_data_out = 32'hFFFF_FFFF;
    for (int i = 0; i < 70010; i++) tick();
    rd_start = 1'b0;
    ram_rd_valid = 1'b0;
    check("t5_sat", 32'(err_cnt), 32'h0000_FFFF);
    check("t5_fadr", first_err_addr, 32'h50);
    check("t5_bcnt", burst_cnt, 32'd2187);

    // 6: reset mid-burst
    ram_rst = 1'b1;
    tick();
    ram_rst = 1'b0;
    tick();
    tick();
    start_burst(32'h600);
    run_beats(32'h600, 0, 10, -1, dones);
    ram_rst = 1'b1;
    ram_rd_valid = 1'b1;
    ram_data_out = 32'h60A;
    tick();
    ram_rst = 1'b0;
    ram_rd_valid = 1'b0;
    check_all_zero("t6_rst");

    // 6b: init drop mid-burst
    tick();
    tick();
    start_burst(32'h700);
    run_beats(32'h700, 0, 32, -1, dones);
    check("t6_bcnt1", burst_cnt, 32'd1);
    start_burst(32'h800);
    run_beats(32'h800, 0, 5, 3, dones);
    check("t6_ecnt", 32'(err_cnt), 32'd1);
    init_cable_complete = 1'b0;
    tick();
    check("t6_drop_busy", 32'(chk_busy), 32'd0);
    run_beats(32'h800, 5, 27, 9, dones);
    check("t6_drop_dones", 32'(dones), 32'd0);
    check("t6_drop_bcnt", burst_cnt, 32'd1);
    check("t6_drop_ecnt", 32'(err_cnt), 32'd1);
    check("t6_drop_fadr", first_err_addr, 32'h803);
    init_cable_complete = 1'b1;
    tick();
    tick();
    start_burst(32'h900);
    run_beats(32'h900, 0, 32, -1, dones);
    check("t6_recover_dones", 32'(dones), 32'd1);
    check("t6_recover_bcnt", burst_cnt, 32'd2);
    check("t6_recover_ecnt", 32'(err_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
